prog_loader: RTL and testbench

- Writer side of the instruction PROM interface.
- Receives a framed byte stream from a host link and assembles 27-bit instruction words.
- Writes those words into the instruction memory that the program counter reads.
- Holds the CPU core in reset (cpu_hold) while a load is in progress, then reports success or checksum failure.

---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 tb/tb_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Writer side of the instruction PROM interface. A host link delivers a framed
// byte stream; this block parses the frame, assembles INSTR_W-bit instruction
// words from 4 big-endian bytes each, writes them into instruction memory and
// keeps the CPU core held in reset while the load is in progress.
//
// Frame (byte order):
//   HDR, addr_hi, addr_lo, cnt_hi, cnt_lo, N x {b3,b2,b1,b0}, chk
//   The 8-bit sum of every byte after HDR, chk included, must be zero.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   in_data     in   [7:0] stream byte
//   in_valid    in   in_data valid
//   in_ready    out  loader accepts a byte (transfer on in_valid && in_ready)
//   imem_we     out  one-cycle instruction memory write strobe
//   imem_waddr  out  [ADDR_W-1:0] write address
//   imem_wdata  out  [INSTR_W-1:0] write data
//   cpu_hold    out  high while a frame is being loaded
//   done        out  one-cycle pulse: frame loaded with a good checksum
//   err         out  sticky checksum-mismatch flag, cleared by the next HDR
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned INSTR_W = 27,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE,
        A_HI,
        A_LO,
        C_HI,
        C_LO,
        DATA,
        WR,
        CHK
    } state_t;

    state_t            state;
    logic [7:0]        hi_q;      // high byte of address / count, held until its low byte arrives
    logic [ADDR_W-1:0] addr;      // next write address, wraps modulo 2^ADDR_W
    logic [15:0]       cnt;       // words still to be written
    logic [1:0]        byte_idx;  // position of the next data byte within its word
    logic [23:0]       word_q;    // first three bytes of the word being assembled
    logic [7:0]        sum;       // running checksum of bytes after HDR

    logic              take;
    logic [7:0]        sum_next;

    // in_ready is registered and tracks the state, so a transfer is simply the
    // handshake seen at the clock edge.
    assign take     = in_valid && in_ready;
    assign sum_next = sum + in_data;

    // NOTE: every register below is assigned with <= so all of them update
    // together from the values present before the edge; a blocking = here
    // would let later statements see half-updated state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hi_q       <= '0;
            addr       <= '0;
            cnt        <= '0;
            byte_idx   <= '0;
            word_q     <= '0;
            sum        <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Strobes default low; in_ready defaults high and is only pulled
            // low for the single write cycle.
            imem_we  <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;

            case (state)
                IDLE: begin
                    // Non-header bytes are consumed and dropped.
                    if (take && in_data == HDR) begin
                        state    <= A_HI;
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                        sum      <= '0;
                    end
                end

                A_HI: begin
                    if (take) begin
                        hi_q  <= in_data;
                        sum   <= sum_next;
                        state <= A_LO;
                    end
                end

                A_LO: begin
                    if (take) begin
                        addr  <= ADDR_W'({hi_q, in_data});
                        sum   <= sum_next;
                        state <= C_HI;
                    end
                end

                C_HI: begin
                    if (take) begin
                        hi_q  <= in_data;
                        sum   <= sum_next;
                        state <= C_LO;
                    end
                end

                C_LO: begin
                    if (take) begin
                        cnt      <= {hi_q, in_data};
                        sum      <= sum_next;
                        byte_idx <= '0;
                        state    <= ({hi_q, in_data} == 16'd0) ? CHK : DATA;
                    end
                end

                DATA: begin
                    if (take) begin
                        word_q   <= {word_q[15:0], in_data};
                        sum      <= sum_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // Fourth byte: issue the write straight from the
                            // assembled bytes so imem_we is high in the next
                            // cycle. The cast drops the unused top bits.
                            state      <= WR;
                            in_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_waddr <= addr;
                            imem_wdata <= INSTR_W'({word_q, in_data});
                        end
                    end
                end

                WR: begin
                    addr  <= addr + ADDR_W'(1);
                    cnt   <= cnt - 16'd1;
                    state <= (cnt == 16'd1) ? CHK : DATA;
                end

                CHK: begin
                    if (take) begin
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                        if (sum_next == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            err  <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Structural invariants of the handshake and status outputs.
    a_we_blocks_input : assert property (
        @(posedge clk) disable iff (!rst) imem_we |-> !in_ready);

    a_done_releases_cpu : assert property (
        @(posedge clk) disable iff (!rst) done |-> (!cpu_hold && !err));

    a_wr_single_cycle : assert property (
        @(posedge clk) disable iff (!rst) (state == WR) |=> (state != WR));

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Scoreboard bench for prog_loader. Each scenario pushes the memory writes and
// frame outcomes it expects into a queue; an independent monitor pops an entry
// whenever the DUT shows imem_we, a done pulse or a rising err, and compares.
// Handshake and status timing is checked inline by the stimulus tasks.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 27;
    localparam logic [7:0]  HDR     = 8'hA5;

    typedef enum logic [1:0] { EV_WR, EV_DONE, EV_ERR } ev_kind_e;

    typedef struct {
        ev_kind_e           kind;
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } ev_t;

    logic               clk;
    logic               rst;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_hold;
    logic               done;
    logic               err;

    ev_t         exp_q[$];
    int          vectors;
    int          miscompares;
    logic        err_prev;
    logic [31:0] words [4];

    prog_loader #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .HDR     (HDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_wr(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        ev_t e;
        e.kind = EV_WR;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_ev(input ev_kind_e k);
        ev_t e;
        e.kind = k;
        e.addr = '0;
        e.data = '0;
        exp_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    task automatic take_event(input ev_kind_e k, input logic [ADDR_W-1:0] a,
                              input logic [INSTR_W-1:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h, expected none (t=%0t)",
                     k, a, d, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (e.kind == EV_WR) begin
                check("write_addr", 32'(a), 32'(e.addr));
                check("write_data", 32'(d), 32'(e.data));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (imem_we)          take_event(EV_WR, imem_waddr, imem_wdata);
            if (done)             take_event(EV_DONE, '0, '0);
            if (err && !err_prev) take_event(EV_ERR, '0, '0);
        end
        err_prev = err;
    end

    // ---------------- stimulus ----------------
    // Starts and ends on a falling edge; returns in the cycle after the byte
    // was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps && $urandom_range(1) == 1) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sends a full frame built from words[0..n-1]; chk is the two's complement
    // of the byte sum plus chk_adj (non-zero corrupts it).
    task automatic send_frame(input logic [15:0] a, input int n, input logic [7:0] chk_adj,
                              input bit exp_good, input bit gaps);
        logic [7:0]  s;
        logic [7:0]  b;
        logic [15:0] nn;
        nn = 16'(n);
        s  = 8'd0;
        check("cpu_hold_before_hdr", 32'(cpu_hold), 32'd0);
        send_byte(HDR, gaps);
        check("cpu_hold_after_hdr", 32'(cpu_hold), 32'd1);
        check("err_after_hdr", 32'(err), 32'd0);
        send_byte(a[15:8], gaps);  s = s + a[15:8];
        send_byte(a[7:0], gaps);   s = s + a[7:0];
        send_byte(nn[15:8], gaps); s = s + nn[15:8];
        send_byte(nn[7:0], gaps);  s = s + nn[7:0];
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = words[i][31-8*j -: 8];
                send_byte(b, gaps);
                s = s + b;
            end
            // Write cycle: input stalled for exactly one cycle.
            check("in_ready_in_wr", 32'(in_ready), 32'd0);
            @(negedge clk);
            check("in_ready_after_wr", 32'(in_ready), 32'd1);
            check("cpu_hold_mid_frame", 32'(cpu_hold), 32'd1);
        end
        send_byte(8'(8'd0 - s) + chk_adj, gaps);
        check("cpu_hold_after_chk", 32'(cpu_hold), 32'd0);
        check("done_after_chk", 32'(done), 32'(exp_good));
        check("err_after_chk", 32'(err), 32'(!exp_good));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        err_prev    = 1'b0;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        rst         = 1'b1;
        #2 rst      = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // 1: single word at 0x010; chk byte works out to 0x1F.
        words[0] = 32'h0123_4567;
        push_wr(10'h010, 27'h123_4567);
        push_ev(EV_DONE);
        send_frame(16'h0010, 1, 8'd0, 1'b1, 1'b0);

        // 2: three words crossing the top of the address space; top 5 bits
        // of each word are dropped.
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h0000_0001;
        words[2] = 32'h0ABC_DEF0;
        push_wr(10'h3FE, 27'h6AD_BEEF);
        push_wr(10'h3FF, 27'h000_0001);
        push_wr(10'h000, 27'h2BC_DEF0);
        push_ev(EV_DONE);
        send_frame(16'h03FE, 3, 8'd0, 1'b1, 1'b0);

        // 3: same frame with chk off by one; writes still land, err is set.
        push_wr(10'h3FE, 27'h6AD_BEEF);
        push_wr(10'h3FF, 27'h000_0001);
        push_wr(10'h000, 27'h2BC_DEF0);
        push_ev(EV_ERR);
        send_frame(16'h03FE, 3, 8'd1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);

        // 4: junk in IDLE is ignored, then an empty frame clears err.
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h12, 1'b0);
        check("err_sticky_after_junk", 32'(err), 32'd1);
        push_ev(EV_DONE);
        send_frame(16'h0000, 0, 8'd0, 1'b1, 1'b0);

        // 5: frame 1 again with random idle cycles between bytes.
        words[0] = 32'h0123_4567;
        push_wr(10'h010, 27'h123_4567);
        push_ev(EV_DONE);
        send_frame(16'h0010, 1, 8'd0, 1'b1, 1'b1);

        // 6: reset after two data bytes, then a clean frame.
        send_byte(HDR, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("cpu_hold_before_abort", 32'(cpu_hold), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_cpu_hold", 32'(cpu_hold), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_imem_we", 32'(imem_we), 32'd0);
        check("abort_waddr", 32'(imem_waddr), 32'd0);
        check("abort_wdata", 32'(imem_wdata), 32'd0);
        check("abort_done_err", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        words[0] = 32'hFFFF_FFFF;
        push_wr(10'h020, 27'h7FF_FFFF);
        push_ev(EV_DONE);
        send_frame(16'h0020, 1, 8'd0, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
